// File: rtl/pe_pkg.sv
// Shared constants and width helpers for the PE input feeder and its FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package pe_pkg;

   localparam int PE_DATA_WIDTH = 64;
   localparam int PE_TILE_LEN   = 9;   // 3x3 kernel

   // Read/write pointer width; wraps naturally because DEPTH is a power of two.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy width: must represent 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return (depth > 0) ? $clog2(depth + 1) : 1;
   endfunction

   // Tile beat counter width, never narrower than one bit.
   function automatic int beat_w(input int tile_len);
      return (tile_len > 1) ? $clog2(tile_len) : 1;
   endfunction

endpackage

// File: rtl/pe_input_feeder_if.sv
// Handshake bundle between fetch logic, PE input feeder and PE controller.
// Latency: n/a (wires only).
// Backpressure: upstream via o_ready, downstream via pe_ack.
// Ports (slave = feeder side):
//   in : i_valid, i_data, pe_ack
//   out: o_ready, o_valid, o_data, o_last, o_tile_done
interface pe_input_feeder_if
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_WIDTH
);
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;
   logic                  o_valid;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_last;
   logic                  pe_ack;
   logic                  o_tile_done;

   modport slave (
      input  i_valid, i_data, pe_ack,
      output o_ready, o_valid, o_data, o_last, o_tile_done
   );

   modport master (
      output i_valid, i_data, pe_ack,
      input  o_ready, o_valid, o_data, o_last, o_tile_done
   );
endinterface

// File: rtl/pe_fwft_fifo.sv
// First-word-fall-through FIFO: storage, pointers and occupancy count.
// Latency: word written in cycle N is at head_o in cycle N+1.
// Backpressure: push ignored when full, pop ignored when empty; no full pass-through.
// Ports: clk, rst (sync, active high), push_i/push_dat_i, pop_i, head_o, count_o.
module pe_fwft_fifo
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_WIDTH,
   parameter int DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic [DATA_WIDTH-1:0]     push_dat_i,
   input  logic                      pop_i,
   output logic [DATA_WIDTH-1:0]     head_o,
   output logic [cnt_w(DEPTH)-1:0]   count_o
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full, empty, push, pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = push_i && !full;
   assign pop   = pop_i && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only words below count are ever presented.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/pe_input_feeder.sv
// PE input feeder: buffers operand words and presents them to the PE with tile framing.
// Latency: one cycle from accepted push to o_valid on an empty FIFO.
// Backpressure: o_ready low while full (even if pe_ack); pops one word per pe_ack with o_valid.
// Ports: clk, rst (sync, active high), bus (pe_input_feeder_if.slave);
//   with PE_INPUT_FEEDER_STATS_EN defined also o_stall_cnt (32b) and o_fill (count width).
module pe_input_feeder
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_WIDTH,
   parameter int DEPTH      = 8,
   parameter int TILE_LEN   = PE_TILE_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   pe_input_feeder_if.slave        bus
`ifdef PE_INPUT_FEEDER_STATS_EN
   ,
   output logic [31:0]             o_stall_cnt,
   output logic [cnt_w(DEPTH)-1:0] o_fill
`endif
);
   localparam int CW = cnt_w(DEPTH);
   localparam int BW = beat_w(TILE_LEN);

   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] head;
   logic                  valid, pop, last;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  tile_done_q, tile_done_d;

   pe_fwft_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (bus.i_valid),
      .push_dat_i (bus.i_data),
      .pop_i      (bus.pe_ack),
      .head_o     (head),
      .count_o    (count)
   );

   assign valid = (count != '0);
   assign pop   = bus.pe_ack && valid;
   // With TILE_LEN=1 the compare is against 0 and beat never leaves 0,
   // so every valid word is flagged last.
   assign last  = valid && (beat_q == BW'(TILE_LEN - 1));

   always_comb begin
      beat_d      = beat_q;
      tile_done_d = 1'b0;
      if (pop) begin
         tile_done_d = last;
         beat_d      = last ? '0 : beat_q + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q      <= '0;
         tile_done_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         tile_done_q <= tile_done_d;
      end
   end

   assign bus.o_ready     = (count < CW'(DEPTH));
   assign bus.o_valid     = valid;
   assign bus.o_data      = head;
   assign bus.o_last      = last;
   assign bus.o_tile_done = tile_done_q;

`ifdef PE_INPUT_FEEDER_STATS_EN
   logic [31:0] stall_q, stall_d;

   // Counts cycles a word waits at the PE; sticks at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (valid && !bus.pe_ack && (stall_q != '1)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign o_stall_cnt = stall_q;
   assign o_fill      = count;
`endif
endmodule

// File: tb/tb_pe_input_feeder.sv
module tb_pe_input_feeder;
   localparam int DW       = 64;
   localparam int DEPTH    = 8;
   localparam int TILE_LEN = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pe_input_feeder_if #(.DATA_WIDTH(DW)) bus ();

`ifdef PE_INPUT_FEEDER_STATS_EN
   logic [31:0] stall_cnt;
   logic [3:0]  fill;
`endif

   pe_input_feeder #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .TILE_LEN   (TILE_LEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef PE_INPUT_FEEDER_STATS_EN
      ,
      .o_stall_cnt (stall_cnt),
      .o_fill      (fill)
`endif
   );

   // Reference model: queue of words, total pops since reset, pending pulse.
   logic [DW-1:0] q[$];
   int            pops;
   logic          done_exp;
   longint        stall_exp;
   int            checks = 0;
   int            errors = 0;
   int            last_seen, done_seen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic cycle(input logic vld, input logic [63:0] dat, input logic ack);
      bit m_push, m_pop, m_last;
      bus.i_valid = vld;
      bus.i_data  = dat;
      bus.pe_ack  = ack;
      #1;
      m_last = (q.size() != 0) && ((pops % TILE_LEN) == TILE_LEN - 1);
      chk("o_ready", bus.o_ready, q.size() < DEPTH);
      chk("o_valid", bus.o_valid, q.size() != 0);
      if (q.size() != 0) chk("o_data", bus.o_data, q[0]);
      chk("o_last", bus.o_last, m_last);
      chk("o_tile_done", bus.o_tile_done, done_exp);
`ifdef PE_INPUT_FEEDER_STATS_EN
      chk("o_fill", fill, q.size());
      chk("o_stall_cnt", stall_cnt, stall_exp);
`endif
      if (bus.o_last === 1'b1) last_seen++;
      if (bus.o_tile_done === 1'b1) done_seen++;
      m_push = vld && (q.size() < DEPTH);
      m_pop  = ack && (q.size() != 0);
      @(posedge clk);
      done_exp = m_pop && m_last;
      if (q.size() != 0 && !ack && stall_exp < 64'hFFFF_FFFF) stall_exp++;
      if (m_pop) begin
         void'(q.pop_front());
         pops++;
      end
      if (m_push) q.push_back(dat);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n, input logic vld);
      rst         = 1'b1;
      bus.i_valid = vld;
      bus.i_data  = rnd64();
      bus.pe_ack  = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      q.delete();
      pops      = 0;
      done_exp  = 1'b0;
      stall_exp = 0;
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.pe_ack  = 1'b0;
      @(negedge clk);

      // Reset held 2 cycles with i_valid asserted: nothing may be stored.
      do_reset(2, 1'b1);
      bus.i_valid = 1'b0;
      #1;
      chk("rst_o_ready", bus.o_ready, 1'b1);
      chk("rst_o_valid", bus.o_valid, 1'b0);
      chk("rst_o_tile_done", bus.o_tile_done, 1'b0);
      cycle(1'b0, '0, 1'b0);
      chk("rst_nothing_stored", bus.o_valid, 1'b0);

      // Single word into an empty FIFO, then held through 5 stall cycles.
      cycle(1'b1, 64'hA1, 1'b0);
      chk("a1_visible", bus.o_valid, 1'b1);
      chk("a1_data", bus.o_data, 64'hA1);
      repeat (5) cycle(1'b0, rnd64(), 1'b0);
      chk("a1_held", bus.o_data, 64'hA1);
      cycle(1'b0, '0, 1'b1);

      // Fill to DEPTH without ack; ninth word refused; ack+valid when full pops only.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd64(), 1'b0);
      chk("full_o_ready", bus.o_ready, 1'b0);
      cycle(1'b1, 64'hDEAD_BEEF, 1'b0);
      chk("ninth_not_stored", bus.o_ready, 1'b0);
      cycle(1'b1, 64'hBAD0_BAD0, 1'b1);
      chk("pop_only_ready", bus.o_ready, 1'b1);
      while (q.size() != 0) cycle(1'b0, '0, 1'b1);

      // 18-word stream with continuous ack: two tiles.
      do_reset(1, 1'b0);
      last_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 2 * TILE_LEN; i++) cycle(1'b1, rnd64(), 1'b1);
      repeat (3) cycle(1'b0, '0, 1'b1);
      chk("stream_last_count", last_seen, 2);
      chk("stream_done_count", done_seen, 2);

      // Abandon a partially consumed tile with reset, then a full tile.
      do_reset(1, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd64(), 1'b0);
      repeat (4) cycle(1'b0, '0, 1'b1);
      do_reset(1, 1'b0);
      last_seen = 0;
      done_seen = 0;
      for (int i = 0; i < TILE_LEN; i++) cycle(1'b1, rnd64(), 1'b1);
      repeat (3) cycle(1'b0, '0, 1'b1);
      chk("abandon_last_count", last_seen, 1);
      chk("abandon_done_count", done_seen, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 200; i++)
         cycle(1'($urandom_range(0, 3) != 0), rnd64(), 1'($urandom_range(0, 3) == 0));
      while (q.size() != 0) cycle(1'b0, '0, 1'b1);

`ifdef PE_INPUT_FEEDER_STATS_EN
      // Statistics: one word waiting 7 cycles.
      do_reset(1, 1'b0);
      cycle(1'b1, rnd64(), 1'b0);
      repeat (7) cycle(1'b0, '0, 1'b0);
      #1;
      chk("stats_stall7", stall_cnt, 32'd7);
      chk("stats_fill1", fill, 4'd1);
      cycle(1'b1, rnd64(), 1'b1);
      cycle(1'b1, rnd64(), 1'b0);
      #1;
      chk("stats_fill2", fill, 4'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pe_input_feeder.md
Name: pe_input_feeder

Overview:
- Upstream stage of the processing-element (PE) controller.
- Buffers operand words from the feature/weight fetch logic in a small first-word-fall-through (FWFT) FIFO.
- Presents them to the PE as o_valid/o_data and pops one word per PE acknowledge (pe_ack).
- Tracks tile boundaries: flags the last word of each TILE_LEN-word tile and pulses when a tile has been fully consumed.

Parameters:
- DATA_WIDTH, 64, width of one operand word.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TILE_LEN, 9, words per PE tile (e.g. 3x3 kernel); at least 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- i_data  input  DATA_WIDTH  upstream word.
- o_ready  output  1  feeder can accept a word this cycle.
- o_valid  output  1  word available to PE; drives PE controller i_valid.
- o_data  output  DATA_WIDTH  head-of-FIFO word.
- o_last  output  1  o_data is the final word of the current tile.
- pe_ack  input  1  PE consumed o_data this cycle.
- o_tile_done  output  1  one-cycle pulse after the last word of a tile is acked.

Behaviour:
- Reset is synchronous active-high on clk. Reset state: count=0, rd_ptr=0, wr_ptr=0, beat=0, o_valid=0, o_last=0, o_tile_done=0, o_ready=1. o_data is don't-care.
- Push occurs when i_valid && o_ready. o_ready = (count < DEPTH), registered-state based. There is no full-with-pop pass-through, so o_ready=0 when full even if pe_ack=1.
- Pop occurs when pe_ack && o_valid. pe_ack while o_valid=0 is ignored; no pointer or beat change.
- o_valid = (count != 0). o_data = mem[rd_ptr], read combinationally from registered state.
- Latency: a word pushed in cycle N into an empty FIFO is visible (o_valid=1) in cycle N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH+1) bits.
- Hold rule: o_data and o_last stay stable while o_valid && !pe_ack.
- Tile tracking:
  - beat counter, $clog2(TILE_LEN) bits (minimum 1), advances on each pop.
  - beat wraps to 0 on the pop where beat == TILE_LEN-1.
  - o_last = o_valid && (beat == TILE_LEN-1).
  - TILE_LEN=1: o_last = o_valid.
- Tile-done pulse: o_tile_done is registered and equals 1 in the cycle after a pop with o_last=1; otherwise 0.
- Back-to-back tiles: consecutive tile-completing pops may yield o_tile_done high on consecutive cycles only when TILE_LEN=1.
- Reset mid-operation: FIFO contents discarded, beat cleared, partially consumed tile abandoned, no o_tile_done generated.
- Overflow is impossible by construction (push gated by o_ready). Underflow is impossible (pop gated by o_valid).

Optional Feature:
- Macro: PE_INPUT_FEEDER_STATS_EN.
- Defined: adds output o_stall_cnt (32 bits) and output o_fill (count width).
  - o_stall_cnt increments each cycle o_valid && !pe_ack, saturates at 2^32-1, clears on rst.
  - o_fill mirrors count.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package pe_pkg holds:
  - localparam functions for pointer, count and beat widths (clog2 helpers, minimum 1).
  - PE_DATA_WIDTH default constant.
  - TILE_LEN default constant (kernel 3x3 = 9).
- One natural sub-module: pe_fwft_fifo, holding storage, pointers and count with push/pop/full/empty.
  - The top level adds beat tracking, o_last, o_tile_done and stats.

Test Plan:
- Reset with rst=1 for 2 cycles while i_valid=1 -> o_ready=1, o_valid=0, o_tile_done=0, no word stored after release.
- Push 0xA1 in cycle N with FIFO empty, pe_ack=0 -> o_valid=1, o_data=0xA1 from N+1; held unchanged for 5 stall cycles.
- Push 8 words without ack (DEPTH=8) -> o_ready=0 after 8th push. Ninth i_valid word not stored. Assert pe_ack and i_valid in the same cycle -> pop only, o_ready=1 next cycle.
- Stream 18 words (TILE_LEN=9) with pe_ack=1 continuously -> o_last high on words 9 and 18 only; o_tile_done pulses one cycle after each.
- Ack 4 of 9 tile words, assert rst for 1 cycle, then stream 9 words -> first o_last on 9th post-reset word, no stray o_tile_done.
- With PE_INPUT_FEEDER_STATS_EN: o_valid=1 with 7 cycles no ack -> o_stall_cnt=7, o_fill matches pushed minus popped.
